// File: rtl/kcounter_updown.sv
// Signed up/down K-counter with programmable symmetric bound +/-L, WRAP or SAT mode.
// Optional macro KCOUNTER_EVENT_STATS_EN adds saturating carry/borrow event counters.
module kcounter_updown #(
  parameter int WIDTH      = 20,
  parameter int STEP_WIDTH = 4
) (
  input  logic                  fpga_clk_i,
  input  logic                  reset_n_i,
  input  logic                  clear_i,
  input  logic [1:0]            count_instr_i,
  input  logic [STEP_WIDTH-1:0] step_i,
  input  logic [WIDTH-2:0]      limit_i,
  input  logic                  mode_i,
  input  logic                  load_i,
  input  logic [WIDTH-1:0]      load_val_i,
  output logic [WIDTH-1:0]      counter_val_o,
  output logic                  carry_o,
  output logic                  borrow_o,
  output logic                  sat_o
`ifdef KCOUNTER_EVENT_STATS_EN
  ,
  output logic [15:0]           carry_count_o,
  output logic [15:0]           borrow_count_o
`endif
);

  localparam int EW = WIDTH + 1;

  logic [WIDTH-1:0]     value_r;
  logic                 carry_r;
  logic                 borrow_r;
  logic                 sat_r;

  logic signed [EW-1:0] val_ext_s;
  logic signed [EW-1:0] lim_pos_s;
  logic signed [EW-1:0] lim_neg_s;
  logic signed [EW-1:0] step_ext_s;
  logic signed [EW-1:0] load_ext_s;
  logic signed [EW-1:0] sum_s;
  logic                 count_en_s;
  logic [WIDTH-1:0]     value_nx_s;
  logic                 carry_nx_s;
  logic                 borrow_nx_s;
  logic                 sat_nx_s;

  // One extra bit of headroom makes value +/- step and the bound compares overflow-free.
  assign val_ext_s  = {value_r[WIDTH-1], value_r};
  assign lim_pos_s  = {2'b00, limit_i};
  assign lim_neg_s  = -lim_pos_s;
  assign step_ext_s = {{(EW-STEP_WIDTH){1'b0}}, step_i};
  assign load_ext_s = {load_val_i[WIDTH-1], load_val_i};
  assign sum_s      = (count_instr_i == 2'b01) ? (val_ext_s + step_ext_s) : (val_ext_s - step_ext_s);

  // Decode whether this cycle is a real up/down count (zero step behaves as hold).
  always_comb begin
    count_en_s = 1'b0;
    case (count_instr_i)
      2'b01:   count_en_s = (step_i != {STEP_WIDTH{1'b0}});
      2'b10:   count_en_s = (step_i != {STEP_WIDTH{1'b0}});
      default: count_en_s = 1'b0;
    endcase
  end

  // Next-state selection: clear > load > count, with bound check on every count.
  always_comb begin
    value_nx_s  = value_r;
    carry_nx_s  = 1'b0;
    borrow_nx_s = 1'b0;
    sat_nx_s    = 1'b0;
    if (clear_i) begin
      value_nx_s = {WIDTH{1'b0}};
    end else if (load_i) begin
      if (load_ext_s > lim_pos_s) begin
        value_nx_s = lim_pos_s[WIDTH-1:0];
      end else if (load_ext_s < lim_neg_s) begin
        value_nx_s = lim_neg_s[WIDTH-1:0];
      end else begin
        value_nx_s = load_val_i;
      end
    end else if (count_en_s) begin
      if (sum_s > lim_pos_s) begin
        if (mode_i) begin
          value_nx_s = lim_pos_s[WIDTH-1:0];
          sat_nx_s   = 1'b1;
        end else begin
          value_nx_s = {WIDTH{1'b0}};
          carry_nx_s = 1'b1;
        end
      end else if (sum_s < lim_neg_s) begin
        if (mode_i) begin
          value_nx_s = lim_neg_s[WIDTH-1:0];
          sat_nx_s   = 1'b1;
        end else begin
          value_nx_s  = {WIDTH{1'b0}};
          borrow_nx_s = 1'b1;
        end
      end else begin
        value_nx_s = sum_s[WIDTH-1:0];
      end
    end else begin
      value_nx_s = value_r;
    end
  end

  // Counter value and one-cycle event pulses.
  always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      value_r  <= {WIDTH{1'b0}};
      carry_r  <= 1'b0;
      borrow_r <= 1'b0;
      sat_r    <= 1'b0;
    end else begin
      value_r  <= value_nx_s;
      carry_r  <= carry_nx_s;
      borrow_r <= borrow_nx_s;
      sat_r    <= sat_nx_s;
    end
  end

  assign counter_val_o = value_r;
  assign carry_o       = carry_r;
  assign borrow_o      = borrow_r;
  assign sat_o         = sat_r;

`ifdef KCOUNTER_EVENT_STATS_EN
  logic [15:0] carry_cnt_r;
  logic [15:0] borrow_cnt_r;

  // Saturating event counters; they advance in the same cycle the pulse appears.
  always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      carry_cnt_r  <= 16'h0000;
      borrow_cnt_r <= 16'h0000;
    end else if (clear_i) begin
      carry_cnt_r  <= 16'h0000;
      borrow_cnt_r <= 16'h0000;
    end else begin
      if (carry_nx_s && (carry_cnt_r != 16'hFFFF)) begin
        carry_cnt_r <= carry_cnt_r + 16'h0001;
      end else begin
        carry_cnt_r <= carry_cnt_r;
      end
      if (borrow_nx_s && (borrow_cnt_r != 16'hFFFF)) begin
        borrow_cnt_r <= borrow_cnt_r + 16'h0001;
      end else begin
        borrow_cnt_r <= borrow_cnt_r;
      end
    end
  end

  assign carry_count_o  = carry_cnt_r;
  assign borrow_count_o = borrow_cnt_r;
`endif

endmodule

// File: tb/tb_kcounter_updown.sv
// Scoreboard bench for kcounter_updown (WIDTH=8); stats checks active with KCOUNTER_EVENT_STATS_EN.
module tb_kcounter_updown;
  localparam int W  = 8;
  localparam int SW = 4;

  logic          fpga_clk_i = 1'b0;
  logic          reset_n_i  = 1'b0;
  logic          clear_i    = 1'b0;
  logic [1:0]    count_instr_i = 2'b00;
  logic [SW-1:0] step_i     = '0;
  logic [W-2:0]  limit_i    = '0;
  logic          mode_i     = 1'b0;
  logic          load_i     = 1'b0;
  logic [W-1:0]  load_val_i = '0;
  logic [W-1:0]  counter_val_o;
  logic          carry_o, borrow_o, sat_o;
`ifdef KCOUNTER_EVENT_STATS_EN
  logic [15:0]   carry_count_o, borrow_count_o;
`endif

  kcounter_updown #(.WIDTH(W), .STEP_WIDTH(SW)) dut (
    .fpga_clk_i    (fpga_clk_i),
    .reset_n_i     (reset_n_i),
    .clear_i       (clear_i),
    .count_instr_i (count_instr_i),
    .step_i        (step_i),
    .limit_i       (limit_i),
    .mode_i        (mode_i),
    .load_i        (load_i),
    .load_val_i    (load_val_i),
    .counter_val_o (counter_val_o),
    .carry_o       (carry_o),
    .borrow_o      (borrow_o),
    .sat_o         (sat_o)
`ifdef KCOUNTER_EVENT_STATS_EN
    ,
    .carry_count_o (carry_count_o),
    .borrow_count_o(borrow_count_o)
`endif
  );

  always #5 fpga_clk_i = ~fpga_clk_i;

  // Row: instr, step, limit, mode, clear, load, load_val, exp value, exp carry, exp borrow, exp sat
  typedef struct {int ins, stp, lim, md, clr, ld, lv, ev, ec, eb, es;} row_t;
  typedef struct packed {logic [7:0] val; logic c; logic b; logic s; logic [15:0] cc; logic [15:0] bc;} exp_t;

  exp_t        sb[$];
  int          nvec = 0;
  int          nfail = 0;
  logic [15:0] mcc = 16'h0000;
  logic [15:0] mbc = 16'h0000;

  task automatic apply(input row_t r);
    exp_t e;
    count_instr_i = r.ins[1:0];
    step_i        = r.stp[SW-1:0];
    limit_i       = r.lim[W-2:0];
    mode_i        = r.md[0];
    clear_i       = r.clr[0];
    load_i        = r.ld[0];
    load_val_i    = r.lv[W-1:0];
    if (r.clr != 0) begin
      mcc = 16'h0000;
      mbc = 16'h0000;
    end else begin
      if (r.ec != 0 && mcc != 16'hFFFF) mcc = mcc + 16'h0001;
      if (r.eb != 0 && mbc != 16'hFFFF) mbc = mbc + 16'h0001;
    end
    e.val = r.ev[7:0];
    e.c = r.ec[0];
    e.b = r.eb[0];
    e.s = r.es[0];
    e.cc = mcc;
    e.bc = mbc;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    row_t rows [5] = '{'{1,1,10,0,0,0,0, 1,0,0,0}, '{1,1,10,0,0,0,0, 2,0,0,0},
                       '{1,1,10,0,0,0,0, 3,0,0,0}, '{1,1,10,0,0,0,0, 4,0,0,0},
                       '{1,1,10,0,0,0,0, 5,0,0,0}};
    #12;
    nvec++;
    if ({counter_val_o, carry_o, borrow_o, sat_o} !== 11'd0) begin
      nfail++;
      $display("FAIL reset_init: got val=%0d c/b/s=%b%b%b, expected 0 000", $signed(counter_val_o), carry_o, borrow_o, sat_o);
    end
    @(negedge fpga_clk_i);
    reset_n_i = 1'b1;
    foreach (rows[i]) begin
      exp_t e;
      apply(rows[i]);
      @(posedge fpga_clk_i); #1;
      e = sb.pop_front();
      nvec++;
      if ({counter_val_o, carry_o, borrow_o, sat_o} !== {e.val, e.c, e.b, e.s}) begin
        nfail++;
        $display("FAIL reset_count[%0d]: got val=%0d c/b/s=%b%b%b, expected val=%0d c/b/s=%b%b%b", i, $signed(counter_val_o), carry_o, borrow_o, sat_o, $signed(e.val), e.c, e.b, e.s);
      end
    end
    #2;
    reset_n_i = 1'b0;
    mcc = 16'h0000;
    mbc = 16'h0000;
    #1;
    nvec++;
    if ({counter_val_o, carry_o, borrow_o, sat_o} !== 11'd0) begin
      nfail++;
      $display("FAIL reset_mid: got val=%0d c/b/s=%b%b%b, expected 0 000", $signed(counter_val_o), carry_o, borrow_o, sat_o);
    end
`ifdef KCOUNTER_EVENT_STATS_EN
    nvec++;
    if ({carry_count_o, borrow_count_o} !== 32'd0) begin
      nfail++;
      $display("FAIL reset_stats: got cc=%0d bc=%0d, expected 0 0", carry_count_o, borrow_count_o);
    end
`endif
    count_instr_i = 2'b00;
    @(negedge fpga_clk_i);
    reset_n_i = 1'b1;
  endtask

  task automatic test_wrap();
    row_t rows [11] = '{'{0,0,10,0,1,0,0, 0,0,0,0},
                        '{1,3,10,0,0,0,0, 3,0,0,0}, '{1,3,10,0,0,0,0, 6,0,0,0},
                        '{1,3,10,0,0,0,0, 9,0,0,0}, '{1,3,10,0,0,0,0, 0,1,0,0},
                        '{1,3,10,0,0,0,0, 3,0,0,0},
                        '{0,0,10,0,1,0,0, 0,0,0,0},
                        '{2,4,10,0,0,0,0, -4,0,0,0}, '{2,4,10,0,0,0,0, -8,0,0,0},
                        '{2,4,10,0,0,0,0, 0,0,1,0}, '{2,4,10,0,0,0,0, -4,0,0,0}};
    foreach (rows[i]) begin
      exp_t e;
      apply(rows[i]);
      @(posedge fpga_clk_i); #1;
      e = sb.pop_front();
      nvec++;
      if ({counter_val_o, carry_o, borrow_o, sat_o} !== {e.val, e.c, e.b, e.s}) begin
        nfail++;
        $display("FAIL wrap[%0d]: got val=%0d c/b/s=%b%b%b, expected val=%0d c/b/s=%b%b%b", i, $signed(counter_val_o), carry_o, borrow_o, sat_o, $signed(e.val), e.c, e.b, e.s);
      end
`ifdef KCOUNTER_EVENT_STATS_EN
      nvec++;
      if ({carry_count_o, borrow_count_o} !== {e.cc, e.bc}) begin
        nfail++;
        $display("FAIL wrap_stats[%0d]: got cc=%0d bc=%0d, expected cc=%0d bc=%0d", i, carry_count_o, borrow_count_o, e.cc, e.bc);
      end
`endif
    end
  endtask

  task automatic test_sat();
    row_t rows [7] = '{'{0,0,10,1,1,0,0, 0,0,0,0},
                       '{1,7,10,1,0,0,0, 7,0,0,0}, '{1,7,10,1,0,0,0, 10,0,0,1},
                       '{1,7,10,1,0,0,0, 10,0,0,1}, '{2,7,10,1,0,0,0, 3,0,0,0},
                       '{2,7,10,1,0,0,0, -4,0,0,0}, '{2,7,10,1,0,0,0, -10,0,0,1}};
    foreach (rows[i]) begin
      exp_t e;
      apply(rows[i]);
      @(posedge fpga_clk_i); #1;
      e = sb.pop_front();
      nvec++;
      if ({counter_val_o, carry_o, borrow_o, sat_o} !== {e.val, e.c, e.b, e.s}) begin
        nfail++;
        $display("FAIL sat[%0d]: got val=%0d c/b/s=%b%b%b, expected val=%0d c/b/s=%b%b%b", i, $signed(counter_val_o), carry_o, borrow_o, sat_o, $signed(e.val), e.c, e.b, e.s);
      end
`ifdef KCOUNTER_EVENT_STATS_EN
      nvec++;
      if ({carry_count_o, borrow_count_o} !== {e.cc, e.bc}) begin
        nfail++;
        $display("FAIL sat_stats[%0d]: got cc=%0d bc=%0d, expected cc=%0d bc=%0d", i, carry_count_o, borrow_count_o, e.cc, e.bc);
      end
`endif
    end
  endtask

  task automatic test_priority_load();
    row_t rows [5] = '{'{1,1,10,0,1,1,50, 0,0,0,0}, '{0,0,10,0,0,1,50, 10,0,0,0},
                       '{1,5,10,0,0,1,-50, -10,0,0,0}, '{3,5,10,0,0,0,0, -10,0,0,0},
                       '{1,0,10,1,0,0,0, -10,0,0,0}};
    foreach (rows[i]) begin
      exp_t e;
      apply(rows[i]);
      @(posedge fpga_clk_i); #1;
      e = sb.pop_front();
      nvec++;
      if ({counter_val_o, carry_o, borrow_o, sat_o} !== {e.val, e.c, e.b, e.s}) begin
        nfail++;
        $display("FAIL prio_load[%0d]: got val=%0d c/b/s=%b%b%b, expected val=%0d c/b/s=%b%b%b", i, $signed(counter_val_o), carry_o, borrow_o, sat_o, $signed(e.val), e.c, e.b, e.s);
      end
    end
  endtask

  task automatic test_limit_zero();
    row_t rows [7] = '{'{0,0,0,0,1,0,0, 0,0,0,0},
                       '{1,1,0,0,0,0,0, 0,1,0,0}, '{2,1,0,0,0,0,0, 0,0,1,0},
                       '{1,2,0,1,0,0,0, 0,0,0,1}, '{2,15,0,1,0,0,0, 0,0,0,1},
                       '{1,0,0,1,0,0,0, 0,0,0,0}, '{0,3,0,0,0,0,0, 0,0,0,0}};
    foreach (rows[i]) begin
      exp_t e;
      apply(rows[i]);
      @(posedge fpga_clk_i); #1;
      e = sb.pop_front();
      nvec++;
      if ({counter_val_o, carry_o, borrow_o, sat_o} !== {e.val, e.c, e.b, e.s}) begin
        nfail++;
        $display("FAIL limit_zero[%0d]: got val=%0d c/b/s=%b%b%b, expected val=%0d c/b/s=%b%b%b", i, $signed(counter_val_o), carry_o, borrow_o, sat_o, $signed(e.val), e.c, e.b, e.s);
      end
    end
  endtask

  task automatic test_back_to_back();
    row_t rows [5] = '{'{0,0,3,0,1,0,0, 0,0,0,0},
                       '{1,4,3,0,0,0,0, 0,1,0,0}, '{1,4,3,0,0,0,0, 0,1,0,0},
                       '{1,4,3,0,0,0,0, 0,1,0,0}, '{1,1,3,0,0,0,0, 1,0,0,0}};
    foreach (rows[i]) begin
      exp_t e;
      apply(rows[i]);
      @(posedge fpga_clk_i); #1;
      e = sb.pop_front();
      nvec++;
      if ({counter_val_o, carry_o, borrow_o, sat_o} !== {e.val, e.c, e.b, e.s}) begin
        nfail++;
        $display("FAIL back_to_back[%0d]: got val=%0d c/b/s=%b%b%b, expected val=%0d c/b/s=%b%b%b", i, $signed(counter_val_o), carry_o, borrow_o, sat_o, $signed(e.val), e.c, e.b, e.s);
      end
    end
  endtask

  task automatic test_limit_shrink_stats();
    row_t rows [16] = '{'{0,0,10,0,1,0,0, 0,0,0,0}, '{0,0,10,0,0,1,9, 9,0,0,0},
                        '{0,0,5,0,0,0,0, 9,0,0,0}, '{3,0,5,0,0,0,0, 9,0,0,0},
                        '{0,0,5,0,0,0,0, 9,0,0,0}, '{1,1,5,0,0,0,0, 0,1,0,0},
                        '{1,6,5,0,0,0,0, 0,1,0,0}, '{1,6,5,0,0,0,0, 0,1,0,0},
                        '{1,6,5,0,0,0,0, 0,1,0,0}, '{0,0,10,0,0,1,9, 9,0,0,0},
                        '{2,1,5,1,0,0,0, 5,0,0,1}, '{0,0,10,0,0,1,9, 9,0,0,0},
                        '{2,1,5,0,0,0,0, 0,1,0,0}, '{2,6,5,0,0,0,0, 0,0,1,0},
                        '{0,0,5,0,1,0,0, 0,0,0,0}, '{2,6,5,1,0,0,0, -5,0,0,1}};
    foreach (rows[i]) begin
      exp_t e;
      apply(rows[i]);
      @(posedge fpga_clk_i); #1;
      e = sb.pop_front();
      nvec++;
      if ({counter_val_o, carry_o, borrow_o, sat_o} !== {e.val, e.c, e.b, e.s}) begin
        nfail++;
        $display("FAIL shrink[%0d]: got val=%0d c/b/s=%b%b%b, expected val=%0d c/b/s=%b%b%b", i, $signed(counter_val_o), carry_o, borrow_o, sat_o, $signed(e.val), e.c, e.b, e.s);
      end
`ifdef KCOUNTER_EVENT_STATS_EN
      nvec++;
      if ({carry_count_o, borrow_count_o} !== {e.cc, e.bc}) begin
        nfail++;
        $display("FAIL shrink_stats[%0d]: got cc=%0d bc=%0d, expected cc=%0d bc=%0d", i, carry_count_o, borrow_count_o, e.cc, e.bc);
      end
`endif
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_wrap();
    test_sat();
    test_priority_load();
    test_limit_zero();
    test_back_to_back();
    test_limit_shrink_stats();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/kcounter_updown.md
Name: kcounter_updown

Overview:
- Parametrised successor to the ADPLL up/down counter; serves as the K-counter / loop-filter stage after the phase detector.
- Accumulates signed up/down steps of programmable size within a programmable symmetric bound ±L.
- WRAP mode: emits one-cycle carry/borrow pulses to the DCO increment/decrement logic.
- SAT mode: clamps at ±L and flags each clamp.

Parameters:
WIDTH, 20, counter width in bits (two's complement signed value)
STEP_WIDTH, 4, width of unsigned step magnitude input

Ports:
fpga_clk_i  in  1  system clock, all state updates on rising edge
reset_n_i  in  1  asynchronous active-low reset
clear_i  in  1  synchronous clear of value and pulses
count_instr_i  in  2  00 hold, 01 up, 10 down, 11 hold
step_i  in  STEP_WIDTH  unsigned step magnitude per count
limit_i  in  WIDTH-1  unsigned bound L; legal range 0..2^(WIDTH-1)-1
mode_i  in  1  0 WRAP, 1 SAT
load_i  in  1  synchronous load strobe
load_val_i  in  WIDTH  signed load value
counter_val_o  out  WIDTH  signed registered counter value
carry_o  out  1  one-cycle pulse on overflow (WRAP)
borrow_o  out  1  one-cycle pulse on underflow (WRAP)
sat_o  out  1  one-cycle pulse when a clamp occurred (SAT)

Behaviour:
- Reset: reset_n_i low asynchronously forces counter_val_o=0, carry_o=0, borrow_o=0, sat_o=0. Deassertion takes effect on the next clock edge.
- Priority per edge: clear_i > load_i > count_instr_i.
- Clear: value<=0; all pulse outputs<=0.
- Load: value<=load_val_i clamped to [-L,+L], no pulses, regardless of mode_i.
- Count:
  - up: next = value + step_i; down: next = value - step_i.
  - Computed sign-extended to WIDTH+1 bits; no internal overflow is possible.
- Bound check on every up/down update, both bounds:
  - WRAP, next > +L: value<=0, carry_o=1.
  - WRAP, next < -L: value<=0, borrow_o=1.
  - SAT, next > +L: value<=+L, sat_o=1.
  - SAT, next < -L: value<=-L, sat_o=1.
  - Otherwise: value<=next, no pulse.
- Hold (00/11), or step_i=0 with up/down: value unchanged, no pulses.
- Pulses last exactly one cycle. Every cycle that does not generate an event drives them 0; they never stretch.
- Latency: one clock from inputs to counter_val_o and to pulses. Pulses align with the cycle the value wraps or clamps.
- Continuous events: up with step ≥ L+1 every cycle in WRAP yields carry_o high every cycle and value stays 0.
- L=0: value held at 0 by any count.
  - WRAP: up gives carry_o, down gives borrow_o.
  - SAT: sat_o fires on any non-zero step.
- limit_i is sampled live each cycle. If L is lowered below |value|, value is kept until the next up/down or load, then resolved by the normal bound check. A step toward zero that still lands outside the bound also triggers wrap/clamp.
- mode_i may change any cycle; it applies to that cycle's update only.
- No outputs depend combinationally on inputs.

Optional Feature:
- Macro: KCOUNTER_EVENT_STATS_EN.
- Defined: adds outputs carry_count_o[15:0] and borrow_count_o[15:0].
  - Each increments on its respective pulse and saturates at 16'hFFFF.
  - Cleared by reset and clear_i; SAT clamps are not counted.
- Undefined: ports and registers are absent; all other behaviour is identical.

Test Plan:
- Reset mid-count: WIDTH=8, L=10, up step 1 for 5 cycles, then assert reset_n_i low between edges -> counter_val_o=0 immediately, no pulses.
- WRAP overflow: L=10, step 3, up from 0 -> values 3,6,9, then 0 with carry_o=1 for exactly that cycle, then 3.
- WRAP underflow: L=10, step 4, down from 0 -> -4,-8, then 0 with borrow_o=1, then -4.
- SAT clamp: mode_i=1, L=10, step 7, up from 0 -> 7, then 10 with sat_o=1, then 10 with sat_o=1 again; down step 7 -> 3, -4, -10 (sat_o=1 on the third).
- Priority/load: clear_i, load_i (load_val_i=50) and up asserted together -> value 0. Then load 50 with L=10 -> 10. Then load -50 -> -10. No pulses throughout.
- Limit shrink and stats (macro on): value 9, set L=5, hold 3 cycles -> stays 9; then up step 1 in WRAP -> 0, carry_o=1, carry_count_o=1. Then 3 more overflows -> carry_count_o=4. clear_i -> counts 0.
